// File: rtl/rps_pkg.sv
// ----------------------------------------------------------------------------
// rps_pkg
// Shared types and helpers for the rock-paper-scissors match arbiter.
//   gesture_e   : 2-bit move encoding (00 is not a legal gesture)
//   state_e     : arbiter FSM states
//   beats()     : 1 when gesture a beats gesture b
//   MAX_PLAYERS : upper bound on NUM_PLAYERS
// ----------------------------------------------------------------------------
package rps_pkg;

    localparam int MAX_PLAYERS = 8;

    typedef enum logic [1:0] {
        ILLEGAL  = 2'b00,
        ROCK     = 2'b01,
        PAPER    = 2'b10,
        SCISSORS = 2'b11
    } gesture_e;

    typedef enum logic [1:0] {
        COLLECT,
        JUDGE,
        UPDATE,
        OVER
    } state_e;

    function automatic logic beats(input gesture_e a, input gesture_e b);
        return ((a == ROCK)     && (b == SCISSORS)) ||
               ((a == SCISSORS) && (b == PAPER))    ||
               ((a == PAPER)    && (b == ROCK));
    endfunction

endpackage

// File: rtl/rps_match_arbiter_judge.sv
// ----------------------------------------------------------------------------
// rps_round_judge
// Combinational referee for one round.
//   moves_i   [2*NUM_PLAYERS-1:0] : latched gestures, player i at [2i+1:2i]
//   winners_o [NUM_PLAYERS-1:0]   : players holding the winning gesture
//   tie_o                         : 1 when one or three distinct gestures
// ----------------------------------------------------------------------------
module rps_round_judge
    import rps_pkg::*;
#(
    parameter int NUM_PLAYERS = 2
) (
    input  logic [2*NUM_PLAYERS-1:0] moves_i,
    output logic [NUM_PLAYERS-1:0]   winners_o,
    output logic                     tie_o
);

    logic [3:1] present;      // indexed by gesture code
    logic [1:0] n_distinct;
    gesture_e   win_g;
    logic       decisive;

    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        present    = '0;
        win_g      = ILLEGAL;
        winners_o  = '0;

        for (int i = 0; i < NUM_PLAYERS; i++) begin
            case (moves_i[2*i +: 2])
                2'b01:   present[1] = 1'b1;
                2'b10:   present[2] = 1'b1;
                2'b11:   present[3] = 1'b1;
                default: ;
            endcase
        end

        n_distinct = 2'(present[1]) + 2'(present[2]) + 2'(present[3]);
        decisive   = (n_distinct == 2'd2);

        // With exactly two gestures present, exactly one of them beats the other.
        for (int g = 1; g < 4; g++) begin
            for (int h = 1; h < 4; h++) begin
                if (present[g] && present[h] &&
                    beats(gesture_e'(g[1:0]), gesture_e'(h[1:0]))) begin
                    win_g = gesture_e'(g[1:0]);
                end
            end
        end

        for (int i = 0; i < NUM_PLAYERS; i++) begin
            winners_o[i] = decisive && (moves_i[2*i +: 2] == win_g);
        end

        tie_o = !decisive;
    end

endmodule

// File: rtl/rps_match_arbiter.sv
// ----------------------------------------------------------------------------
// rps_match_arbiter
// Rock-paper-scissors referee for NUM_PLAYERS players with per-player
// valid/ready move submission, saturating scores, tie and round counters.
//   clk, rst (async, active high)
//   move_valid/move/move_ready : per-player gesture handshake
//   match_clear                : synchronous clear, overrides everything
//   busy                       : high in JUDGE and UPDATE
//   round_done/round_winners   : one-cycle result pulse and held winner set
//   scores/tie_count/round_cnt : match statistics
//   illegal_move               : pulse after a 00 gesture was offered
//   match_over/match_winner    : level, players that reached WIN_TARGET
// ----------------------------------------------------------------------------
module rps_match_arbiter
    import rps_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 8,
    parameter int WIN_TARGET  = 3,
    parameter int ROUND_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PLAYERS-1:0]         move_valid,
    input  logic [2*NUM_PLAYERS-1:0]       move,
    output logic [NUM_PLAYERS-1:0]         move_ready,
    input  logic                           match_clear,
    output logic                           busy,
    output logic                           round_done,
    output logic [NUM_PLAYERS-1:0]         round_winners,
    output logic [SCORE_W*NUM_PLAYERS-1:0] scores,
    output logic [SCORE_W-1:0]             tie_count,
    output logic [ROUND_W-1:0]             round_cnt,
    output logic                           illegal_move,
    output logic                           match_over,
    output logic [NUM_PLAYERS-1:0]         match_winner
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] WIN_T     = SCORE_W'(WIN_TARGET);

    state_e state_q, state_d;

    logic [NUM_PLAYERS-1:0]              latched_q;
    logic [2*NUM_PLAYERS-1:0]            moves_q, moves_d;
    logic [NUM_PLAYERS-1:0]              winners_q;
    logic                                tie_q;
    logic [NUM_PLAYERS-1:0][SCORE_W-1:0] scores_q, scores_d;
    logic [SCORE_W-1:0]                  tie_count_q;
    logic [ROUND_W-1:0]                  round_cnt_q;
    logic [NUM_PLAYERS-1:0]              round_winners_q;
    logic                                round_done_q;
    logic                                illegal_q;
    logic                                match_over_q;
    logic [NUM_PLAYERS-1:0]              match_winner_q;

    logic [NUM_PLAYERS-1:0] legal;
    logic [NUM_PLAYERS-1:0] accept;
    logic [NUM_PLAYERS-1:0] hit;
    logic                   illegal_seen;
    logic                   all_in;
    logic [NUM_PLAYERS-1:0] judge_winners;
    logic                   judge_tie;

    // ------------------------------------------------------------------
    // Handshake: ready only in COLLECT for players not yet latched; a clear
    // blocks every handshake in its own cycle.
    // ------------------------------------------------------------------
    always_comb begin
        legal = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            legal[i] = (move[2*i +: 2] != ILLEGAL);
        end
    end

    assign move_ready   = ((state_q == COLLECT) && !match_clear) ? ~latched_q : '0;
    assign accept       = move_valid & move_ready & legal;
    assign illegal_seen = |(move_valid & move_ready & ~legal);
    assign all_in       = &(latched_q | accept);

    always_comb begin
        moves_d = moves_q;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (accept[i]) moves_d[2*i +: 2] = move[2*i +: 2];
        end
    end

    rps_round_judge #(
        .NUM_PLAYERS (NUM_PLAYERS)
    ) u_judge (
        .moves_i   (moves_q),
        .winners_o (judge_winners),
        .tie_o     (judge_tie)
    );

    // ------------------------------------------------------------------
    // Score update computed from the registered winner vector; hit marks
    // players whose updated score reaches the target.
    // ------------------------------------------------------------------
    always_comb begin
        scores_d = scores_q;
        hit      = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (winners_q[i] && (scores_q[i] != SCORE_MAX)) begin
                scores_d[i] = scores_q[i] + SCORE_W'(1);
            end
            hit[i] = (scores_d[i] >= WIN_T);
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (match_clear) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: if (all_in) state_d = JUDGE;
                JUDGE:   state_d = UPDATE;
                UPDATE:  state_d = (|hit) ? OVER : COLLECT;
                OVER:    state_d = OVER;
                default: state_d = COLLECT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latched_q       <= '0;
            moves_q         <= '0;
            winners_q       <= '0;
            tie_q           <= 1'b0;
            scores_q        <= '0;
            tie_count_q     <= '0;
            round_cnt_q     <= '0;
            round_winners_q <= '0;
            round_done_q    <= 1'b0;
            illegal_q       <= 1'b0;
            match_over_q    <= 1'b0;
            match_winner_q  <= '0;
        end else if (match_clear) begin
            // Discards any round in flight, so no round_done follows.
            latched_q       <= '0;
            moves_q         <= '0;
            winners_q       <= '0;
            tie_q           <= 1'b0;
            scores_q        <= '0;
            tie_count_q     <= '0;
            round_cnt_q     <= '0;
            round_winners_q <= '0;
            round_done_q    <= 1'b0;
            illegal_q       <= 1'b0;
            match_over_q    <= 1'b0;
            match_winner_q  <= '0;
        end else begin
            round_done_q <= 1'b0;
            illegal_q    <= illegal_seen;
            case (state_q)
                COLLECT: begin
                    moves_q   <= moves_d;
                    latched_q <= latched_q | accept;
                end
                JUDGE: begin
                    winners_q <= judge_winners;
                    tie_q     <= judge_tie;
                end
                UPDATE: begin
                    scores_q        <= scores_d;
                    if (tie_q && (tie_count_q != SCORE_MAX)) begin
                        tie_count_q <= tie_count_q + SCORE_W'(1);
                    end
                    round_cnt_q     <= round_cnt_q + ROUND_W'(1);
                    round_winners_q <= winners_q;
                    round_done_q    <= 1'b1;
                    latched_q       <= '0;
                    moves_q         <= '0;
                    if (|hit) begin
                        match_over_q   <= 1'b1;
                        match_winner_q <= hit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state_q == JUDGE) || (state_q == UPDATE);
    assign round_done    = round_done_q;
    assign round_winners = round_winners_q;
    assign scores        = scores_q;
    assign tie_count     = tie_count_q;
    assign round_cnt     = round_cnt_q;
    assign illegal_move  = illegal_q;
    assign match_over    = match_over_q;
    assign match_winner  = match_winner_q;

endmodule

// File: doc/rps_match_arbiter.md
Name: rps_match_arbiter

Overview:
Parametrised rock-paper-scissors referee for NUM_PLAYERS players. Each player has its own valid/ready handshake for submitting a gesture. Once all moves are in, the block judges the round and updates saturating scores and a tie counter. It declares the match over when any score reaches WIN_TARGET. It sits between player agents/stimulus and the scoreboard, replacing the fixed two-player, unclocked-trigger arbiter.

Parameters:
NUM_PLAYERS, 2, number of players (2..8)
SCORE_W, 8, width of each score and the tie counter
WIN_TARGET, 3, score that ends the match (1..2**SCORE_W-1)
ROUND_W, 16, width of the round counter

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
move_valid  input  NUM_PLAYERS  per-player move offered
move  input  2*NUM_PLAYERS  per-player gesture, player i at [2i+1:2i]; 01=ROCK, 10=PAPER, 11=SCISSORS, 00=illegal
move_ready  output  NUM_PLAYERS  per-player move accepted when valid&ready
match_clear  input  1  synchronous clear of scores, ties, rounds and latched moves
busy  output  1  high while judging/updating
round_done  output  1  one-cycle pulse, round result valid
round_winners  output  NUM_PLAYERS  players that won the last round (all 0 = tie)
scores  output  SCORE_W*NUM_PLAYERS  per-player score, player i at [SCORE_W*(i+1)-1:SCORE_W*i]
tie_count  output  SCORE_W  number of tied rounds
round_cnt  output  ROUND_W  rounds completed
illegal_move  output  1  one-cycle pulse when any offered move is 00
match_over  output  1  level, set when any score reaches WIN_TARGET
match_winner  output  NUM_PLAYERS  players whose score reached WIN_TARGET

Behaviour:
- Reset (async, rst=1): state=COLLECT; all outputs 0 except move_ready = all ones; latched moves cleared.
- States: COLLECT -> JUDGE -> UPDATE -> (COLLECT | OVER). OVER -> COLLECT only on match_clear.
- COLLECT: move_ready[i]=1 until player i's move is latched, then 0 for the rest of the round.
  - A move with gesture 00 is not accepted. illegal_move pulses the next cycle and ready stays high.
  - Leave COLLECT the cycle after all NUM_PLAYERS moves are latched. Moves may arrive in any order and any cycle.
- JUDGE (1 cycle, busy=1): compute the set of distinct gestures present.
  - 1 or 3 distinct gestures: tie.
  - Exactly 2 distinct gestures: every holder of the beating gesture wins. ROCK beats SCISSORS, SCISSORS beats PAPER, PAPER beats ROCK.
  - The winner vector is registered.
- UPDATE (1 cycle, busy=1):
  - Add 1 to each winner's score, saturating at 2**SCORE_W-1; on a tie, add 1 to tie_count, saturating.
  - round_cnt+1, wrapping.
  - round_done pulses and round_winners is updated. Both are visible the cycle after UPDATE, along with the new scores.
  - Latched moves are cleared.
  - If any updated score >= WIN_TARGET: go to OVER, set match_over=1 and match_winner = all such players (simultaneous winners allowed). Otherwise go to COLLECT.
- Latency: last handshake in cycle N -> round_done high in cycle N+3.
- OVER: move_ready=0; scores are held.
- match_clear: legal in any state and wins over everything else.
  - move_ready is forced to 0 in that cycle, so no handshake occurs.
  - Next cycle: state=COLLECT, and scores, tie_count, round_cnt, match_over, match_winner, round_winners and latched moves are all 0.
  - A round in progress (JUDGE/UPDATE) is discarded with no round_done.
- round_winners holds its value until the next round_done or clear.
- move_valid may drop without a handshake; there is no penalty.

Decomposition:
- Package rps_pkg:
  - gesture_e enum (ILLEGAL=2'b00, ROCK, PAPER, SCISSORS)
  - state_e enum (COLLECT, JUDGE, UPDATE, OVER)
  - function beats(a,b) returning 1 if gesture a beats gesture b
  - MAX_PLAYERS=8 constant
- Sub-module rps_round_judge: purely combinational. Takes the NUM_PLAYERS latched gestures and returns the winner vector and a tie flag. It is instantiated once and registered in JUDGE.

Test Plan:
- N=2: P0 ROCK, P1 SCISSORS, same cycle -> round_done 3 cycles later; round_winners=01, scores=(1,0), round_cnt=1.
- N=3: ROCK, PAPER, SCISSORS -> tie, round_winners=000, tie_count=1, scores unchanged. Then ROCK, ROCK, PAPER -> winners=100, P2 score=1.
- N=2: P0 offers 00 -> illegal_move pulse, move_ready[0] stays 1. Then P0 offers PAPER and P1 offers ROCK two cycles later -> winners=01.
- WIN_TARGET=3, N=3: P0 and P1 both PAPER vs P2 ROCK for 3 rounds -> match_over=1, match_winner=011, move_ready=000. Further valid moves are ignored.
- SCORE_W=2, WIN_TARGET=3: P0 wins 3 rounds -> score saturates at 3 and match_over=1. After match_clear, next round tie_count increments from 0.
- match_clear asserted in the JUDGE cycle -> no round_done; all counters are 0 next cycle and move_ready is all ones the cycle after.
